// File: rtl/vote_cast_controller_if.sv
// ----------------------------------------------------------------------------
// vote_cast_controller_if
// Bundles the voting-machine signals exchanged between the vote cast
// controller and its environment.
//   mode                    : 0 = voting, 1 = result mode
//   candidate_button_press  : raw candidate buttons, bit n = candidate n
//   cand_1_vote..cand_4_vote: per-candidate vote counts
//   valid_vote_casted       : one-cycle pulse per accepted vote
//   busy                    : controller not idle
//   total_votes             : sum of all counts (only with VOTE_TOTAL_EN)
// Modports: master drives mode/buttons, slave is the controller.
// Optional macro: VOTE_TOTAL_EN adds total_votes.
// ----------------------------------------------------------------------------
interface vote_cast_controller_if #(
    parameter int CNT_W = 8
);
    logic             mode;
    logic [4:1]       candidate_button_press;
    logic [CNT_W-1:0] cand_1_vote;
    logic [CNT_W-1:0] cand_2_vote;
    logic [CNT_W-1:0] cand_3_vote;
    logic [CNT_W-1:0] cand_4_vote;
    logic             valid_vote_casted;
    logic             busy;
`ifdef VOTE_TOTAL_EN
    logic [CNT_W+1:0] total_votes;

    modport master (
        output mode, candidate_button_press,
        input  cand_1_vote, cand_2_vote, cand_3_vote, cand_4_vote,
        input  valid_vote_casted, busy, total_votes
    );
    modport slave (
        input  mode, candidate_button_press,
        output cand_1_vote, cand_2_vote, cand_3_vote, cand_4_vote,
        output valid_vote_casted, busy, total_votes
    );
`else
    modport master (
        output mode, candidate_button_press,
        input  cand_1_vote, cand_2_vote, cand_3_vote, cand_4_vote,
        input  valid_vote_casted, busy
    );
    modport slave (
        input  mode, candidate_button_press,
        output cand_1_vote, cand_2_vote, cand_3_vote, cand_4_vote,
        output valid_vote_casted, busy
    );
`endif
endinterface

// File: rtl/vote_cast_controller.sv
// ----------------------------------------------------------------------------
// vote_cast_controller
// Debounces four candidate buttons, rejects multi-button presses, casts one
// vote per press followed by a lockout window, and owns the four saturating
// per-candidate vote counters.
// Ports:
//   clock : system clock (posedge)
//   reset : synchronous, active-high
//   bus   : vote_cast_controller_if.slave (mode, buttons, counts, pulse, busy)
// Optional macro: VOTE_TOTAL_EN adds bus.total_votes (sum of all counts).
// ----------------------------------------------------------------------------
module vote_cast_controller #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int LOCKOUT_CYCLES  = 1000,
    parameter int CNT_W           = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    vote_cast_controller_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [LK_W-1:0]  LK_ONE  = LK_W'(1);
    localparam logic [LK_W-1:0]  LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_COMMIT,
        S_WAIT_RELEASE,
        S_LOCKOUT
    } state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  pat_q, pat_d;
    logic [1:0]                  idx_q, idx_d;
    logic [DB_W-1:0]             db_cnt_q, db_cnt_d;
    logic [LK_W-1:0]             lk_cnt_q, lk_cnt_d;
    logic                        valid_q;
    logic                        busy_q;
    logic [3:0][CNT_W-1:0]       cnt_q;
`ifdef VOTE_TOTAL_EN
    logic [CNT_W+1:0]            total_q;
`endif

    logic [3:0] btn;
    logic       btn_single;
    logic [DB_W-1:0] db_next;

    assign btn        = bus.candidate_button_press;
    assign btn_single = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
    // Number of consecutive matching samples including the current one.
    assign db_next    = db_cnt_q + DB_ONE;

    function automatic logic [1:0] enc(input logic [3:0] b);
        logic [1:0] r;
        r = 2'd0;
        case (b)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        idx_d    = idx_q;
        db_cnt_d = db_cnt_q;
        lk_cnt_d = lk_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.mode && btn != 4'd0) begin
                    if (btn_single) begin
                        pat_d    = btn;
                        idx_d    = enc(btn);
                        db_cnt_d = DB_ONE;
                        // The IDLE sample already counts as the first stable
                        // cycle, so a one-cycle debounce commits immediately.
                        state_d  = (DB_LAST == DB_ONE) ? S_COMMIT : S_DEBOUNCE;
                    end else begin
                        state_d = S_WAIT_RELEASE;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (bus.mode || btn == 4'd0) begin
                    state_d = S_IDLE;
                end else if (btn != pat_q) begin
                    state_d = S_WAIT_RELEASE;
                end else begin
                    db_cnt_d = db_next;
                    if (db_next == DB_LAST) state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_WAIT_RELEASE;
            end
            S_WAIT_RELEASE: begin
                if (btn == 4'd0) begin
                    state_d  = S_LOCKOUT;
                    lk_cnt_d = '0;
                end
            end
            S_LOCKOUT: begin
                if (lk_cnt_q == LK_LAST) begin
                    state_d  = S_IDLE;
                    lk_cnt_d = '0;
                end else begin
                    lk_cnt_d = lk_cnt_q + LK_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pat_q    <= '0;
            idx_q    <= '0;
            db_cnt_q <= '0;
            lk_cnt_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef VOTE_TOTAL_EN
            total_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            idx_q    <= idx_d;
            db_cnt_q <= db_cnt_d;
            lk_cnt_q <= lk_cnt_d;
            // Flags are registered from the next state so they line up with
            // the state they describe.
            valid_q  <= (state_d == S_COMMIT);
            busy_q   <= (state_d != S_IDLE);
            // Count lands on the edge leaving COMMIT; saturated counters hold.
            if (state_q == S_COMMIT && cnt_q[idx_q] != CNT_MAX) begin
                cnt_q[idx_q] <= cnt_q[idx_q] + 1'b1;
`ifdef VOTE_TOTAL_EN
                total_q      <= total_q + 1'b1;
`endif
            end
        end
    end

    assign bus.cand_1_vote       = cnt_q[0];
    assign bus.cand_2_vote       = cnt_q[1];
    assign bus.cand_3_vote       = cnt_q[2];
    assign bus.cand_4_vote       = cnt_q[3];
    assign bus.valid_vote_casted = valid_q;
    assign bus.busy              = busy_q;
`ifdef VOTE_TOTAL_EN
    assign bus.total_votes       = total_q;
`endif
endmodule

// File: tb/tb_vote_cast_controller.sv
// ----------------------------------------------------------------------------
// tb_vote_cast_controller
// Directed scenarios plus randomized button/mode/reset traffic, compared
// every cycle against a behavioural model of the voting rules.
// ----------------------------------------------------------------------------
module tb_vote_cast_controller;
    localparam int DB   = 4;
    localparam int LK   = 8;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    // model phases (behavioural, not the RTL encoding)
    localparam int P_IDLE = 0, P_STABLE = 1, P_VOTE = 2, P_HELD = 3, P_LOCK = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vote_cast_controller_if #(.CNT_W(CW)) vif ();

    vote_cast_controller #(
        .DEBOUNCE_CYCLES(DB),
        .LOCKOUT_CYCLES (LK),
        .CNT_W          (CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (vif)
    );

    int n_chk = 0;
    int n_bad = 0;
    int npulse = 0;

    int         m_cnt [4];
    int         m_total;
    int         m_ph;
    int         m_run;
    int         m_left;
    logic [3:0] m_pat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d @%0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one clock edge's worth of voting rules to the model.
    task automatic model_edge();
        logic [3:0] b;
        int         idx;
        b = vif.candidate_button_press;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_total = 0;
            m_ph    = P_IDLE;
            m_run   = 0;
            m_left  = 0;
            return;
        end
        case (m_ph)
            P_IDLE: if (!vif.mode && b != 4'd0) begin
                if ($countones(b) == 1) begin
                    m_pat = b;
                    m_run = 1;
                    m_ph  = (m_run >= DB) ? P_VOTE : P_STABLE;
                end else m_ph = P_HELD;
            end
            P_STABLE: begin
                if (vif.mode || b == 4'd0) m_ph = P_IDLE;
                else if (b != m_pat)       m_ph = P_HELD;
                else begin
                    m_run++;
                    if (m_run >= DB) m_ph = P_VOTE;
                end
            end
            P_VOTE: begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (m_pat[i]) idx = i;
                if (m_cnt[idx] < MAXC) begin
                    m_cnt[idx]++;
                    m_total++;
                end
                m_ph = P_HELD;
            end
            P_HELD: if (b == 4'd0) begin
                m_ph   = P_LOCK;
                m_left = LK;
            end
            P_LOCK: begin
                m_left--;
                if (m_left == 0) m_ph = P_IDLE;
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_edge();
        chk("valid", vif.valid_vote_casted, (m_ph == P_VOTE) ? 1 : 0);
        chk("busy",  vif.busy,              (m_ph != P_IDLE) ? 1 : 0);
        chk("cand1", vif.cand_1_vote, m_cnt[0]);
        chk("cand2", vif.cand_2_vote, m_cnt[1]);
        chk("cand3", vif.cand_3_vote, m_cnt[2]);
        chk("cand4", vif.cand_4_vote, m_cnt[3]);
`ifdef VOTE_TOTAL_EN
        chk("total", vif.total_votes, m_total);
`endif
        if (vif.valid_vote_casted === 1'b1) npulse++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int p0, nbusy, k, len;
        vif.mode = 1'b0;
        vif.candidate_button_press = 4'd0;
        m_pat = 4'd0;
        reset = 1'b1;
        ticks(3);
        chk("rst_busy",  vif.busy, 0);
        chk("rst_valid", vif.valid_vote_casted, 0);
        chk("rst_cnt2",  vif.cand_2_vote, 0);
        reset = 1'b0;
        ticks(7);

        // Candidate 2 held: pulse exactly 4 edges after first sample.
        vif.candidate_button_press = 4'b0010;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) chk("c2_busy_early", vif.busy, 1);
            chk("c2_pulse_timing", vif.valid_vote_casted, (i == 4) ? 1 : 0);
            if (i == 4) chk("c2_cnt_before", vif.cand_2_vote, 0);
            if (i == 5) begin
                chk("c2_cnt_after", vif.cand_2_vote, 1);
                chk("c2_others", vif.cand_1_vote + vif.cand_3_vote + vif.cand_4_vote, 0);
            end
        end
        vif.candidate_button_press = 4'd0;
        ticks(12);

        // Short press on candidate 1: no vote.
        p0 = npulse;
        vif.candidate_button_press = 4'b0001;
        ticks(2);
        vif.candidate_button_press = 4'd0;
        ticks(12);
        chk("short_pulses", npulse - p0, 0);
        chk("short_cnt1", vif.cand_1_vote, 0);

        // Candidates 1 and 3 together: rejected, then full lockout.
        p0 = npulse;
        vif.candidate_button_press = 4'b0101;
        ticks(20);
        chk("multi_busy", vif.busy, 1);
        vif.candidate_button_press = 4'd0;
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (vif.busy === 1'b1) nbusy++;
        end
        chk("multi_lock_len", nbusy, LK);
        chk("multi_pulses", npulse - p0, 0);

        // Candidate 4 twice, second press starting inside lockout.
        p0 = npulse;
        vif.candidate_button_press = 4'b1000;
        ticks(6);
        vif.candidate_button_press = 4'd0;
        ticks(3);
        vif.candidate_button_press = 4'b1000;
        ticks(20);
        vif.candidate_button_press = 4'd0;
        ticks(12);
        chk("c4_pulses", npulse - p0, 2);
        chk("c4_cnt", vif.cand_4_vote, 2);

        // Result mode: button 3 ignored.
        p0 = npulse;
        vif.mode = 1'b1;
        vif.candidate_button_press = 4'b0100;
        ticks(50);
        vif.candidate_button_press = 4'd0;
        tick();
        vif.mode = 1'b0;
        ticks(2);
        chk("mode_pulses", npulse - p0, 0);
        chk("mode_cnt3", vif.cand_3_vote, 0);

        // Reset mid-debounce.
        vif.candidate_button_press = 4'b0001;
        ticks(2);
        reset = 1'b1;
        tick();
        chk("rstmid_busy", vif.busy, 0);
        chk("rstmid_cnt4", vif.cand_4_vote, 0);
        chk("rstmid_cnt2", vif.cand_2_vote, 0);
        reset = 1'b0;
        vif.candidate_button_press = 4'd0;
        ticks(3);

        // Saturate candidate 1, then one more vote.
        for (int v = 0; v < MAXC; v++) begin
            vif.candidate_button_press = 4'b0001;
            ticks(DB + 1);
            vif.candidate_button_press = 4'd0;
            ticks(LK + 2);
        end
        chk("sat_cnt_pre", vif.cand_1_vote, MAXC);
        p0 = npulse;
        vif.candidate_button_press = 4'b0001;
        ticks(DB + 1);
        vif.candidate_button_press = 4'd0;
        ticks(LK + 2);
        chk("sat_pulse", npulse - p0, 1);
        chk("sat_cnt", vif.cand_1_vote, MAXC);
`ifdef VOTE_TOTAL_EN
        chk("sat_total", vif.total_votes, MAXC);
`endif

        // Randomized traffic.
        for (int s = 0; s < 400; s++) begin
            k   = $urandom_range(0, 9);
            len = $urandom_range(1, 12);
            if (k < 5)      vif.candidate_button_press = 4'(1 << $urandom_range(0, 3));
            else if (k < 7) vif.candidate_button_press = 4'd0;
            else            vif.candidate_button_press = 4'($urandom_range(0, 15));
            vif.mode = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < len; c++) begin
                tick();
                reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
